// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types and constants for the register-file write scheduler.
//   wb_req_t : one queued writeback (destination index + data) at default widths
//   rr_ptr_e : round-robin owner used when only one slot is free
package regfile_wb_pkg;

   localparam int unsigned WB_ADDRESS_WIDTH = 5;
   localparam int unsigned WB_DATA_WIDTH    = 32;

   localparam int unsigned REG_ZERO = 0;
   localparam bit          RR_A     = 1'b0;
   localparam bit          RR_B     = 1'b1;

   typedef struct packed {
      logic [WB_ADDRESS_WIDTH-1:0] addr;
      logic [WB_DATA_WIDTH-1:0]    data;
   } wb_req_t;

   typedef enum logic {
      PTR_A = RR_A,
      PTR_B = RR_B
   } rr_ptr_e;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Bus bundle between the writeback producers / decode and the scheduler.
//   iA*/iB*      : producer request channels (valid, addr, data) with oAReady/oBReady
//   iQueryAddr   : forwarding lookup, answered by oQueryHit/oQueryData
//   oWrite*      : registered register-file write port
//   oCount       : FIFO occupancy
// master = producer/decode side, slave = scheduler side.
interface regfile_write_scheduler_if
   import regfile_wb_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
   parameter int unsigned DATA_WIDTH    = WB_DATA_WIDTH,
   parameter int unsigned DEPTH         = 4
);

   logic                         iAValid;
   logic [ADDRESS_WIDTH-1:0]     iAAddr;
   logic [DATA_WIDTH-1:0]        iAData;
   logic                         oAReady;
   logic                         iBValid;
   logic [ADDRESS_WIDTH-1:0]     iBAddr;
   logic [DATA_WIDTH-1:0]        iBData;
   logic                         oBReady;
   logic [ADDRESS_WIDTH-1:0]     iQueryAddr;
   logic                         oQueryHit;
   logic [DATA_WIDTH-1:0]        oQueryData;
   logic                         oWriteEn;
   logic [ADDRESS_WIDTH-1:0]     oWriteAddress;
   logic [DATA_WIDTH-1:0]        oWriteData;
   logic [$clog2(DEPTH+1)-1:0]   oCount;

   modport master (
      output iAValid, iAAddr, iAData, iBValid, iBAddr, iBData, iQueryAddr,
      input  oAReady, oBReady, oQueryHit, oQueryData,
             oWriteEn, oWriteAddress, oWriteData, oCount
   );

   modport slave (
      input  iAValid, iAAddr, iAData, iBValid, iBAddr, iBData, iQueryAddr,
      output oAReady, oBReady, oQueryHit, oQueryData,
             oWriteEn, oWriteAddress, oWriteData, oCount
   );

endinterface

// File: rtl/regfile_write_scheduler_fifo.sv
// wb_fifo: circular buffer with up to two enqueues and one dequeue per cycle.
//   i_enq0/i_data0 : first (older) enqueue, written at the tail
//   i_enq1/i_data1 : second (younger) enqueue, only used together with i_enq0
//   i_deq          : pop the head (ignored when empty)
//   o_head         : current head entry
//   o_entries      : raw storage, indexed by slot
//   o_valid        : per-slot occupancy mask
//   o_rd_ptr       : slot of the head, for age-ordered searches
//   o_count        : occupancy 0..DEPTH
module wb_fifo
   import regfile_wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = wb_req_t
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_enq0,
   input  T                              i_data0,
   input  logic                          i_enq1,
   input  T                              i_data1,
   input  logic                          i_deq,
   output T                              o_head,
   output T                              o_entries [DEPTH],
   output logic [DEPTH-1:0]              o_valid,
   output logic [$clog2(DEPTH)-1:0]      o_rd_ptr,
   output logic [$clog2(DEPTH+1)-1:0]    o_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   T                r_mem [DEPTH];
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic            w_deq;

   assign w_deq = i_deq && (r_count != '0);

   // Storage carries no reset; occupancy is tracked by the pointers alone.
   always_ff @(posedge i_clk) begin
      if (i_enq0) r_mem[r_wr_ptr] <= i_data0;
      if (i_enq1) r_mem[PW'(r_wr_ptr + 1'b1)] <= i_data1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PW'(i_enq0) + PW'(i_enq1);
         r_rd_ptr <= r_rd_ptr + PW'(w_deq);
         r_count  <= r_count + CW'(i_enq0) + CW'(i_enq1) - CW'(w_deq);
      end
   end

   always_comb begin
      o_valid = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (i < 32'(r_count)) o_valid[PW'(r_rd_ptr + PW'(i))] = 1'b1;
      end
   end

   assign o_head    = r_mem[r_rd_ptr];
   assign o_entries = r_mem;
   assign o_rd_ptr  = r_rd_ptr;
   assign o_count   = r_count;

endmodule

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: merges two writeback channels into the single
// register-file write port, in program order, one write per cycle.
//   iClk, iRst : clock, asynchronous active-high reset
//   bus        : slave side of regfile_write_scheduler_if
//                (A/B request channels, forwarding query, write port, occupancy)
module regfile_write_scheduler
   import regfile_wb_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
   parameter int unsigned DATA_WIDTH    = WB_DATA_WIDTH,
   parameter int unsigned DEPTH         = 4
) (
   input  logic                        iClk,
   input  logic                        iRst,
   regfile_write_scheduler_if.slave    bus
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned FW = CW + 1;

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    data;
   } req_t;

   req_t                     w_req_a;
   req_t                     w_req_b;
   req_t                     w_d0;
   req_t                     w_head;
   req_t                     w_entries [DEPTH];
   logic [DEPTH-1:0]         w_valid;
   logic [PW-1:0]            w_rd_ptr;
   logic [CW-1:0]            w_count;
   logic                     w_deq;
   logic [FW-1:0]            w_free;
   logic                     w_a_ready;
   logic                     w_b_ready;
   logic                     w_enq_a;
   logic                     w_enq_b;
   logic                     w_q_hit;
   logic [DATA_WIDTH-1:0]    w_q_data;
   rr_ptr_e                  r_rr;
   rr_ptr_e                  w_rr_next;
   logic                     r_wr_en;
   logic [ADDRESS_WIDTH-1:0] r_wr_addr;
   logic [DATA_WIDTH-1:0]    r_wr_data;

   assign w_req_a = '{addr: bus.iAAddr, data: bus.iAData};
   assign w_req_b = '{addr: bus.iBAddr, data: bus.iBData};

   // Head drains unconditionally, so its slot is free for this cycle's enqueue.
   assign w_deq  = (w_count != '0);
   assign w_free = FW'(DEPTH) - FW'(w_count) + FW'(w_deq);

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) r_rr <= PTR_A;
      else      r_rr <= w_rr_next;
   end

   always_comb begin
      w_a_ready = 1'b0;
      w_b_ready = 1'b0;
      w_rr_next = r_rr;
      if (w_free >= FW'(2)) begin
         w_a_ready = 1'b1;
         w_b_ready = 1'b1;
      end else if (w_free == FW'(1)) begin
         unique case ({bus.iAValid, bus.iBValid})
            2'b10: w_a_ready = 1'b1;
            2'b01: w_b_ready = 1'b1;
            2'b11: begin
               if (r_rr == PTR_A) begin
                  w_a_ready = 1'b1;
                  w_rr_next = PTR_B;
               end else begin
                  w_b_ready = 1'b1;
                  w_rr_next = PTR_A;
               end
            end
            default: ;
         endcase
      end
   end

   a_free_nonzero: assert property (@(posedge iClk) disable iff (iRst) w_free != '0);

   assign w_enq_a = bus.iAValid && w_a_ready;
   assign w_enq_b = bus.iBValid && w_b_ready;
   // A is older, so it always takes the first slot when both transfer.
   assign w_d0    = w_enq_a ? w_req_a : w_req_b;

   wb_fifo #(
      .DEPTH (DEPTH),
      .T     (req_t)
   ) u_fifo (
      .i_clk     (iClk),
      .i_rst     (iRst),
      .i_enq0    (w_enq_a || w_enq_b),
      .i_data0   (w_d0),
      .i_enq1    (w_enq_a && w_enq_b),
      .i_data1   (w_req_b),
      .i_deq     (w_deq),
      .o_head    (w_head),
      .o_entries (w_entries),
      .o_valid   (w_valid),
      .o_rd_ptr  (w_rd_ptr),
      .o_count   (w_count)
   );

   // x0 entries still drain and update address/data, but never raise the enable.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else if (w_deq) begin
         r_wr_en   <= (w_head.addr != ADDRESS_WIDTH'(REG_ZERO));
         r_wr_addr <= w_head.addr;
         r_wr_data <= w_head.data;
      end else begin
         r_wr_en   <= 1'b0;
      end
   end

   // Walk oldest to youngest so the last match seen is the youngest write.
   always_comb begin
      w_q_hit  = 1'b0;
      w_q_data = '0;
      if (r_wr_en && (r_wr_addr == bus.iQueryAddr)) begin
         w_q_hit  = 1'b1;
         w_q_data = r_wr_data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (w_valid[PW'(w_rd_ptr + PW'(i))] &&
             (w_entries[PW'(w_rd_ptr + PW'(i))].addr == bus.iQueryAddr)) begin
            w_q_hit  = 1'b1;
            w_q_data = w_entries[PW'(w_rd_ptr + PW'(i))].data;
         end
      end
      if (bus.iQueryAddr == ADDRESS_WIDTH'(REG_ZERO)) begin
         w_q_hit  = 1'b0;
         w_q_data = '0;
      end
   end

   assign bus.oAReady       = w_a_ready;
   assign bus.oBReady       = w_b_ready;
   assign bus.oQueryHit     = w_q_hit;
   assign bus.oQueryData    = w_q_data;
   assign bus.oWriteEn      = r_wr_en;
   assign bus.oWriteAddress = r_wr_addr;
   assign bus.oWriteData    = r_wr_data;
   assign bus.oCount        = w_count;

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Writer-side front end for the 32x32 register file write port.
- Collects writeback requests from two producers:
  - channel A: ALU/execute result;
  - channel B: load/long-latency unit result.
- Buffers the requests in program order in a small FIFO and drives exactly one register write per cycle.
- Exposes a forwarding query port so decode can see pending (not yet committed) writes.

Parameters:
- ADDRESS_WIDTH, 5, register index width.
- DATA_WIDTH, 32, register data width.
- DEPTH, 4, FIFO entries (power of 2, >=2); excludes the output stage.

Ports:
- iClk  in  1  clock; all state updates on posedge.
- iRst  in  1  asynchronous active-high reset.
- iAValid  in  1  channel A request valid.
- iAAddr  in  ADDRESS_WIDTH  channel A destination register.
- iAData  in  DATA_WIDTH  channel A write data.
- oAReady  out  1  channel A accepted this cycle (combinational).
- iBValid  in  1  channel B request valid.
- iBAddr  in  ADDRESS_WIDTH  channel B destination register.
- iBData  in  DATA_WIDTH  channel B write data.
- oBReady  out  1  channel B accepted this cycle (combinational).
- iQueryAddr  in  ADDRESS_WIDTH  forwarding lookup address.
- oQueryHit  out  1  a pending write to iQueryAddr exists.
- oQueryData  out  DATA_WIDTH  data of the youngest pending write to iQueryAddr.
- oWriteEn  out  1  to register file write enable (registered).
- oWriteAddress  out  ADDRESS_WIDTH  to register file write address (registered).
- oWriteData  out  DATA_WIDTH  to register file write data (registered).
- oCount  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (async, iRst=1): FIFO empty, oCount=0, oWriteEn=0, oWriteAddress=0, oWriteData=0, round-robin pointer=A.
  - Any requests in flight are discarded.
  - Outputs hold their reset values until the first posedge after iRst deasserts.
- Transfer: a channel's request transfers when Valid && Ready are both high at the posedge.
- Free slots: free = DEPTH - oCount + (oCount>0 ? 1 : 0). The head dequeues every cycle, so the dequeue slot is counted.
- Grant rules:
  - free>=2: both channels ready. If both transfer, A is enqueued before B (A is older).
  - free==1: one grant. If only one channel is valid, that channel gets it. If both are valid, the channel named by the round-robin pointer gets it, then the pointer flips to the other channel.
  - free==0: cannot occur because the drain is unconditional; assertion required.
- Drain: each posedge, if the FIFO is non-empty, the head moves into the output stage and oWriteEn=1.
  - Otherwise oWriteEn=0; oWriteAddress/oWriteData hold their last values.
  - The register file commits on the following negedge.
- Latency: with an empty FIFO, a request accepted at posedge k is held in the FIFO after edge k. It appears on oWrite* after posedge k+1, i.e. 1 cycle of buffering plus 1 output register.
- x0 writes: accepted and queued normally, but on the output oWriteEn=0 (the output stage suppresses the write).
- Ordering: strict FIFO order; same-address writes commit in acceptance order.
- oCount semantics: next = oCount + enq - deq, where enq is 0..2 and deq is (oCount>0). Range 0..DEPTH. Pointers wrap modulo DEPTH.
- Query (combinational):
  - Searches the output stage (when oWriteEn=1) plus all FIFO entries.
  - Youngest match wins: FIFO tail-most first, then older entries, then the output stage.
  - iQueryAddr==0 always gives hit=0.
  - On a miss, oQueryData=0.
  - Same-cycle incoming requests are not visible to the query.

Decomposition:
- Package regfile_wb_pkg:
  - typedef wb_req_t {addr, data};
  - localparams REG_ZERO=0, RR_A=0, RR_B=1.
- Sub-module wb_fifo:
  - dual-enqueue / single-dequeue circular buffer;
  - exposes its entries and valid mask for the query search.
- Top level holds the arbitration, output stage and query mux.

Test Plan:
- Reset mid-stream:
  - Stimulus: queue 3 writes, assert iRst between edges.
  - Required: oWriteEn=0, oCount=0 immediately; no queued write is ever emitted afterwards.
- Single write:
  - Stimulus: A writes x5=0xDEADBEEF at edge k.
  - Required: oWriteEn=1, addr=5, data=0xDEADBEEF after edge k+1; oWriteEn=0 after edge k+2.
- Dual enqueue order:
  - Stimulus: A x3=0x11 and B x3=0x22 in the same cycle.
  - Required: x3=0x11 emitted first, x3=0x22 on the next cycle. A query of x3 before the second commit returns 0x22.
- Fill and round-robin:
  - Stimulus: both channels valid continuously from empty.
  - Required: oCount climbs to 4; then one grant per cycle alternating A, B, A, B; never more than 4 entries.
- x0 handling:
  - Stimulus: B writes x0=0xFFFF.
  - Required: entry accepted, oWriteEn stays 0 on its drain cycle; a query of x0 returns hit=0.
- Query miss:
  - Stimulus: queue x7 only, query x8.
  - Required: hit=0, data=0; a query of x7 returns hit=1 until the cycle after its output stage is vacated.
